// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load / launch from the host side,
// instruction word and status toward the control unit.
interface instr_fetch_if #(
   parameter int INSTR_WIDTH = 20,
   parameter int ADDR_BITS   = 5
);
   logic                   start;
   logic                   prog_we;
   logic [ADDR_BITS-1:0]   prog_addr;
   logic [INSTR_WIDTH-1:0] prog_data;
   logic [INSTR_WIDTH-1:0] instr;
   logic [ADDR_BITS-1:0]   pc;
   logic                   busy;
   logic                   halted;

   modport master (
      output start, prog_we, prog_addr, prog_data,
      input  instr, pc, busy, halted
   );

   modport slave (
      input  start, prog_we, prog_addr, prog_data,
      output instr, pc, busy, halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program memory plus PC, holding each word
// on instr for the control unit's per-class cycle count.
module instr_fetch #(
   parameter int INSTR_WIDTH  = 20,
   parameter int ADDR_BITS    = 5,
   parameter int STD_CYCLES   = 3,
   parameter int LOAD_CYCLES  = 4,
   parameter int STORE_CYCLES = 3
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam int MAXH0 = (STD_CYCLES > LOAD_CYCLES) ?
                          STD_CYCLES : LOAD_CYCLES;
   localparam int MAXH  = (MAXH0 > STORE_CYCLES) ?
                          MAXH0 : STORE_CYCLES;
   localparam int CW    = $clog2(MAXH + 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_q, halted_q;

   logic [ADDR_BITS-1:0]   pc_nxt;
   logic [INSTR_WIDTH-1:0] w_first, w_nxt;
   logic                   launch, first_end, last;

   function automatic logic [CW-1:0] hold(
      input logic [INSTR_WIDTH-1:0] w
   );
      logic [1:0] t;
      t = w[INSTR_WIDTH-1 -: 2];
      hold = '0;
      unique case (1'b1)
         (t == 2'b01): hold = CW'(STD_CYCLES);
         (t == 2'b10): hold = CW'(LOAD_CYCLES);
         (t == 2'b11): hold = CW'(STORE_CYCLES);
         default:      hold = '0;
      endcase
   endfunction

   function automatic logic is_end(
      input logic [INSTR_WIDTH-1:0] w
   );
      is_end = (w[INSTR_WIDTH-1 -: 2] == 2'b00);
   endfunction

   assign pc_nxt    = pc_q + 1'b1;
   assign w_first   = mem[0];
   assign w_nxt     = mem[pc_nxt];
   assign launch    = bus.start && !bus.prog_we;
   assign first_end = is_end(w_first);
   // Top address never wraps back to 0; it ends the program.
   assign last      = (pc_q == ADDR_BITS'(DEPTH - 1)) ||
                      is_end(w_nxt);

   always_ff @(posedge clk) begin
      if (bus.prog_we && state_q != S_ISSUE)
         mem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         pc_q     <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         busy_q   <= (state_d == S_ISSUE);
         halted_q <= (state_d == S_HALT);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (launch)
               state_d = first_end ? S_HALT : S_ISSUE;
         end
         S_ISSUE: begin
            if (cnt_q == CW'(1) && last)
               state_d = S_HALT;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            // Extra cycle covers the CU leaving RESET on the first word.
            if (launch && !first_end) begin
               instr_d = w_first;
               pc_d    = '0;
               cnt_d   = hold(w_first) + CW'(1);
            end
         end
         S_ISSUE: begin
            if (cnt_q == CW'(1)) begin
               if (last) begin
                  instr_d = '0;
                  cnt_d   = '0;
               end else begin
                  pc_d    = pc_nxt;
                  instr_d = w_nxt;
                  cnt_d   = hold(w_nxt);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HALT: begin
            instr_d = '0;
            cnt_d   = '0;
         end
         default: begin
            instr_d = '0;
            pc_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.instr  = instr_q;
   assign bus.pc     = pc_q;
   assign bus.busy   = busy_q;
   assign bus.halted = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model expands each
// launch into a per-cycle trace that a monitor compares every clock.
module tb_instr_fetch;
   localparam int IW = 20;
   localparam int AB = 5;
   localparam int D  = 32;

   typedef struct packed {
      logic [IW-1:0] instr;
      logic [AB-1:0] pc;
      logic          busy;
      logic          halted;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_if #(.INSTR_WIDTH(IW), .ADDR_BITS(AB)) bus ();

   instr_fetch #(
      .INSTR_WIDTH(IW), .ADDR_BITS(AB),
      .STD_CYCLES(3), .LOAD_CYCLES(4), .STORE_CYCLES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   obs_t          exp_q[$];
   obs_t          trace[$];
   logic [IW-1:0] mdl_mem[D];
   int            mode;
   logic [AB-1:0] last_pc;
   int            n_chk  = 0;
   int            n_fail = 0;
   int            busy_cnt = 0;

   function automatic int hold(input logic [IW-1:0] w);
      case (w[19:18])
         2'b01:   return 3;
         2'b10:   return 4;
         2'b11:   return 3;
         default: return 0;
      endcase
   endfunction

   // Expand the whole program from memory image into the cycles it occupies.
   task automatic build_trace();
      obs_t o;
      int   n;
      trace.delete();
      last_pc = '0;
      for (int i = 0; i < D; i++) begin
         if (mdl_mem[i][19:18] == 2'b00) break;
         n = hold(mdl_mem[i]) + ((i == 0) ? 1 : 0);
         o = '{instr: mdl_mem[i], pc: AB'(i), busy: 1'b1, halted: 1'b0};
         for (int k = 0; k < n; k++) trace.push_back(o);
         last_pc = AB'(i);
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic we,
                      input logic [AB-1:0] a, input logic [IW-1:0] d);
      obs_t e;
      @(negedge clk);
      rst = r;
      bus.start = s;
      bus.prog_we = we;
      bus.prog_addr = a;
      bus.prog_data = d;
      e = '0;
      if (r) begin
         trace.delete();
         mode = 0;
         last_pc = '0;
      end else begin
         case (mode)
            0: begin
               if (we) mdl_mem[a] = d;
               else if (s) begin
                  build_trace();
                  mode = 1;
               end
            end
            2: if (we) mdl_mem[a] = d;
            default: ;
         endcase
         if (mode == 1) begin
            if (trace.size() > 0) e = trace.pop_front();
            else mode = 2;
         end
         if (mode == 2) e = '{instr: '0, pc: last_pc, busy: 1'b0,
                              halted: 1'b1};
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic wr(input int a, input logic [IW-1:0] d);
      cyc(1'b0, 1'b0, 1'b1, AB'(a), d);
   endtask

   task automatic go();
      cyc(1'b0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic do_rst();
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic load_t2();
      wr(0, 20'h5B000);
      wr(1, 20'h84050);
      wr(2, 20'hC4050);
      wr(3, 20'h00000);
   endtask

   initial begin : monitor
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (bus.busy === 1'b1) busy_cnt++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{instr: bus.instr, pc: bus.pc, busy: bus.busy,
                  halted: bus.halted};
            n_chk++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL cycle t=%0t got instr=%h pc=%0d busy=%b halted=%b required instr=%h pc=%0d busy=%b halted=%b",
                        $time, g.instr, g.pc, g.busy, g.halted,
                        e.instr, e.pc, e.busy, e.halted);
            end
         end
      end
   end

   initial begin : stim
      int len;
      logic [IW-1:0] w;
      bus.start = 1'b0;
      bus.prog_we = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      mode = 0;
      last_pc = '0;

      do_rst();
      do_rst();
      idle(2);

      // single std word then end marker
      wr(0, 20'h5B000);
      wr(1, 20'h00000);
      go();
      idle(8);

      // std, load, store back to back
      do_rst();
      load_t2();
      go();
      idle(16);

      // empty program
      do_rst();
      wr(0, 20'h00000);
      go();
      idle(3);

      // full memory: stops at the top address without wrapping
      do_rst();
      for (int i = 0; i < D; i++) wr(i, 20'h5B000);
      @(negedge clk);
      busy_cnt = 0;
      go();
      idle(104);
      n_chk++;
      if (busy_cnt != 97) begin
         n_fail++;
         $display("FAIL busy_total got=%0d required=97", busy_cnt);
      end

      // reset mid word 1, then replay
      do_rst();
      load_t2();
      go();
      idle(5);
      do_rst();
      idle(1);
      go();
      idle(16);

      // writes during ISSUE ignored, start+we in IDLE, write in HALT
      do_rst();
      load_t2();
      go();
      idle(2);
      wr(1, 20'h00000);
      cyc(1'b0, 1'b1, 1'b0, '0, '0);
      idle(14);
      do_rst();
      cyc(1'b0, 1'b1, 1'b1, AB'(5), 20'h9ABCD);
      idle(2);
      go();
      idle(14);
      wr(1, 20'h00000);
      do_rst();
      go();
      idle(8);

      // randomized programs with interleaved writes, starts, resets
      for (int it = 0; it < 40; it++) begin
         do_rst();
         len = $urandom_range(0, D);
         for (int i = 0; i < len; i++) begin
            w = IW'($urandom);
            w[19:18] = 2'($urandom_range(1, 3));
            wr(i, w);
         end
         if (len < D) begin
            w = IW'($urandom);
            w[19:18] = 2'b00;
            wr(len, w);
         end
         if ($urandom_range(0, 3) == 0)
            cyc(1'b0, 1'b1, 1'b1, AB'($urandom), IW'($urandom));
         go();
         for (int c = $urandom_range(1, 140); c > 0; c--) begin
            case ($urandom_range(0, 7))
               0: cyc(1'b0, 1'b0, 1'b1, AB'($urandom), IW'($urandom));
               1: cyc(1'b0, 1'b1, 1'b0, '0, '0);
               2: cyc(1'b0, 1'b1, 1'b1, AB'($urandom), IW'($urandom));
               default: idle(1);
            endcase
         end
      end

      do_rst();
      idle(2);
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
